// File: rtl/accel_spi_pkg.sv
// Shared constants, FSM state type and address helpers for the accelerometer SPI responder.
package accel_spi_pkg;

  localparam logic [5:0] ADDR_DEVID   = 6'h00;
  localparam logic [5:0] ADDR_INT_EN  = 6'h2E;
  localparam logic [5:0] ADDR_INT_SRC = 6'h30;
  localparam logic [5:0] ADDR_DATAX0  = 6'h32;
  localparam logic [5:0] ADDR_DATAZ1  = 6'h37;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2,
    WDATA = 2'd3
  } state_t;

  // Sample registers DATAX0..DATAZ1
  function automatic logic is_sample_addr(input logic [5:0] addr);
    return (addr >= ADDR_DATAX0) && (addr <= ADDR_DATAZ1);
  endfunction

  // Registers the initiator may not overwrite
  function automatic logic is_read_only(input logic [5:0] addr);
    return (addr == ADDR_DEVID) || (addr == ADDR_INT_SRC) || is_sample_addr(addr);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Pin synchronisers for SCLK/CS_N/SDAT plus edge strobes derived from the synced levels.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic sdat,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic cs_n_s,
  output logic sdat_s
);

  logic [SYNC_STAGES-1:0] sclk_ff;
  logic [SYNC_STAGES-1:0] cs_ff;
  logic [SYNC_STAGES-1:0] sdat_ff;
  logic                   sclk_prev;
  logic                   cs_prev;

  // Synchroniser chains reset to the idle level of each pin so no edge appears after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_ff   <= '1;
      cs_ff     <= '1;
      sdat_ff   <= '1;
      sclk_prev <= 1'b1;
      cs_prev   <= 1'b1;
    end else begin
      sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], sclk};
      cs_ff     <= {cs_ff[SYNC_STAGES-2:0], cs_n};
      sdat_ff   <= {sdat_ff[SYNC_STAGES-2:0], sdat};
      sclk_prev <= sclk_ff[SYNC_STAGES-1];
      cs_prev   <= cs_ff[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_ff[SYNC_STAGES-1] & ~sclk_prev;
  assign sclk_fall = ~sclk_ff[SYNC_STAGES-1] & sclk_prev;
  assign cs_fall   = ~cs_ff[SYNC_STAGES-1] & cs_prev;
  assign cs_rise   = cs_ff[SYNC_STAGES-1] & ~cs_prev;
  assign cs_n_s    = cs_ff[SYNC_STAGES-1];
  assign sdat_s    = sdat_ff[SYNC_STAGES-1];

endmodule

// File: rtl/accel_spi_responder.sv
// SPI mode-3 responder emulating the G-sensor register file for hardware-in-loop tests.
// state | meaning
// IDLE  | CS_N high, waiting for CS_N fall
// CMD   | shifting in the command byte (rw, mb, addr)
// RDATA | shifting out reg[addr] on SCLK fall, byte end on the following rise
// WDATA | shifting in data on SCLK rise, write on the 8th bit
module accel_spi_responder
  import accel_spi_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID_VAL   = 8'hE5
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        spi_sclk_i,
  input  logic        spi_cs_n_i,
  input  logic        sdat_i,
  output logic        sdat_o,
  output logic        sdat_oe,
  output logic        int_o,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z
);

  logic        sclk_rise, sclk_fall, cs_fall, cs_rise, cs_n_s, sdat_s;
  state_t      state_q, state_d;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift_in, shift_out;
  logic [7:0]  shift_next;
  logic [5:0]  addr;
  logic        mb;
  logic [7:0]  regs [64];
  logic        pend_valid;
  logic [15:0] pend_x, pend_y, pend_z;
  logic        cmd_done, rd_byte_end, wr_byte_end, read_burst, pend_apply;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .sclk      (spi_sclk_i),
    .cs_n      (spi_cs_n_i),
    .sdat      (sdat_i),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .cs_n_s    (cs_n_s),
    .sdat_s    (sdat_s)
  );

  assign shift_next  = {shift_in[6:0], sdat_s};
  assign cmd_done    = (state_q == CMD)   && sclk_rise && (bit_cnt == 4'd7) && !cs_n_s;
  assign rd_byte_end = (state_q == RDATA) && sclk_rise && (bit_cnt == 4'd8) && !cs_n_s;
  assign wr_byte_end = (state_q == WDATA) && sclk_rise && (bit_cnt == 4'd7) && !cs_n_s;
  // Samples are held back while the initiator is reading so a burst sees one coherent sample
  assign read_burst  = (state_q == RDATA) && !cs_n_s;
  assign pend_apply  = pend_valid && (cs_rise || (state_q != RDATA));

  // FSM state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Next-state logic; CS_N high overrides everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = CMD;
      CMD:     if (cmd_done) state_d = shift_next[7] ? RDATA : WDATA;
      default: ;
    endcase
    if (cs_n_s) state_d = IDLE;
  end

  // Shifters, bit counter, address pointer and pad drive
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bit_cnt   <= 4'd0;
      shift_in  <= 8'h00;
      shift_out <= 8'h00;
      addr      <= 6'd0;
      mb        <= 1'b0;
      sdat_o    <= 1'b1;
      sdat_oe   <= 1'b0;
    end else if (cs_n_s) begin
      bit_cnt <= 4'd0;
      sdat_o  <= 1'b1;
      sdat_oe <= 1'b0;
    end else begin
      unique case (state_q)
        CMD: begin
          if (sclk_rise) begin
            shift_in <= shift_next;
            if (cmd_done) begin
              bit_cnt <= 4'd0;
              mb      <= shift_next[6];
              addr    <= shift_next[5:0];
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        RDATA: begin
          if (sclk_fall) begin
            sdat_oe <= 1'b1;
            bit_cnt <= bit_cnt + 4'd1;
            // Byte is fetched at its first fall so a stepped address is already in place
            if (bit_cnt == 4'd0) begin
              sdat_o    <= regs[addr][7];
              shift_out <= {regs[addr][6:0], 1'b0};
            end else begin
              sdat_o    <= shift_out[7];
              shift_out <= {shift_out[6:0], 1'b0};
            end
          end
          if (rd_byte_end) begin
            bit_cnt <= 4'd0;
            if (mb) addr <= addr + 6'd1;
          end
        end
        WDATA: begin
          if (sclk_rise) begin
            shift_in <= shift_next;
            if (wr_byte_end) begin
              bit_cnt <= 4'd0;
              if (mb) addr <= addr + 6'd1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        default: bit_cnt <= 4'd0;
      endcase
    end
  end

  // Pending sample buffer; a newer sample replaces an older one
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pend_valid <= 1'b0;
      pend_x     <= 16'h0000;
      pend_y     <= 16'h0000;
      pend_z     <= 16'h0000;
    end else if (sample_valid && read_burst) begin
      pend_valid <= 1'b1;
      pend_x     <= sample_x;
      pend_y     <= sample_y;
      pend_z     <= sample_z;
    end else if (pend_apply) begin
      pend_valid <= 1'b0;
    end
  end

  // Register file: initiator writes, sample capture and INT_SOURCE handling; capture is last so it wins
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
      regs[ADDR_DEVID] <= DEVID_VAL;
    end else begin
      if (pend_apply) begin
        regs[ADDR_DATAX0]         <= pend_x[7:0];
        regs[ADDR_DATAX0 + 6'd1]  <= pend_x[15:8];
        regs[ADDR_DATAX0 + 6'd2]  <= pend_y[7:0];
        regs[ADDR_DATAX0 + 6'd3]  <= pend_y[15:8];
        regs[ADDR_DATAX0 + 6'd4]  <= pend_z[7:0];
        regs[ADDR_DATAX0 + 6'd5]  <= pend_z[15:8];
        regs[ADDR_INT_SRC][7]     <= 1'b1;
      end
      if (wr_byte_end && !is_read_only(addr)) regs[addr] <= shift_next;
      if (rd_byte_end && is_sample_addr(addr)) regs[ADDR_INT_SRC][7] <= 1'b0;
      if (sample_valid && !read_burst) begin
        regs[ADDR_DATAX0]         <= sample_x[7:0];
        regs[ADDR_DATAX0 + 6'd1]  <= sample_x[15:8];
        regs[ADDR_DATAX0 + 6'd2]  <= sample_y[7:0];
        regs[ADDR_DATAX0 + 6'd3]  <= sample_y[15:8];
        regs[ADDR_DATAX0 + 6'd4]  <= sample_z[7:0];
        regs[ADDR_DATAX0 + 6'd5]  <= sample_z[15:8];
        regs[ADDR_INT_SRC][7]     <= 1'b1;
      end
    end
  end

  // Registered interrupt from enabled sources
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) int_o <= 1'b0;
    else                int_o <= |(regs[ADDR_INT_SRC] & regs[ADDR_INT_EN]);
  end

endmodule

// File: tb/tb_accel_spi_responder.sv
// Bench for accel_spi_responder: SPI initiator driver, register-level reference model and read-byte scoreboard.
`timescale 1ns/1ps
module tb_accel_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b1;
  logic        cs_n = 1'b1;
  logic        sdat = 1'b1;
  logic        sdat_o, sdat_oe, int_o;
  logic        sv = 1'b0;
  logic [15:0] sx = 16'h0, sy = 16'h0, sz = 16'h0;

  int total = 0;
  int bad = 0;

  logic [7:0] model [64];
  logic [7:0] wbuf [8];
  logic [7:0] sb_q [$];

  always #5 clk = ~clk;

  accel_spi_responder dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .spi_sclk_i    (sclk),
    .spi_cs_n_i    (cs_n),
    .sdat_i        (sdat),
    .sdat_o        (sdat_o),
    .sdat_oe       (sdat_oe),
    .int_o         (int_o),
    .sample_valid  (sv),
    .sample_x      (sx),
    .sample_y      (sy),
    .sample_z      (sz)
  );

  // ---------------- reference model ----------------
  function automatic bit ro(input logic [5:0] a);
    return (a == 6'h00) || (a == 6'h30) || (a >= 6'h32 && a <= 6'h37);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
    model[0] = 8'hE5;
  endfunction

  function automatic void model_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    model[6'h32] = x[7:0]; model[6'h33] = x[15:8];
    model[6'h34] = y[7:0]; model[6'h35] = y[15:8];
    model[6'h36] = z[7:0]; model[6'h37] = z[15:8];
    model[6'h30][7] = 1'b1;
  endfunction

  function automatic logic exp_int();
    return |(model[6'h30] & model[6'h2E]);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- monitor: initiator-side receive, compared against scoreboard ----------------
  logic [7:0] rx = 8'h00;
  int nb = 0;
  always @(posedge sclk or posedge cs_n) begin
    logic [7:0] e;
    if (cs_n) nb = 0;
    else if (sdat_oe) begin
      rx = {rx[6:0], sdat_o};
      nb++;
      if (nb == 8) begin
        nb = 0;
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL rd_byte: got %h, no byte expected", rx);
        end else begin
          e = sb_q.pop_front();
          if (rx !== e) begin
            bad++;
            $display("FAIL rd_byte: got %h want %h", rx, e);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_h();
    repeat (8) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sclk = 1'b0; sdat = b; wait_h();
    sclk = 1'b1; wait_h();
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk); sv = 1'b1; sx = x; sy = y; sz = z;
    @(negedge clk); sv = 1'b0;
  endtask

  task automatic sample_now(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    pulse_sample(x, y, z);
    model_sample(x, y, z);
  endtask

  // abort_bits >= 0: the last byte is cut after that many bits; mid_after = k (>0): sample after byte k
  task automatic spi_xfer(input bit rw, input bit mb, input bit [5:0] addr, input int nbytes,
                          input int abort_bits, input int mid_after);
    bit [5:0]    a;
    bit [7:0]    cmd;
    logic [7:0]  d;
    bit          pend;
    logic [15:0] px, py, pz;
    int          nfull;
    cmd = {rw, mb, addr};
    a = addr; pend = 1'b0;
    px = 16'h0; py = 16'h0; pz = 16'h0;
    nfull = (abort_bits >= 0) ? nbytes - 1 : nbytes;
    cs_n = 1'b0; wait_h();
    for (int i = 7; i >= 0; i--) send_bit(cmd[i]);
    if (rw) check("oe_turnaround", {15'h0, sdat_oe}, 16'h0);
    for (int b = 0; b < nfull; b++) begin
      if (rw) begin
        sb_q.push_back(model[a]);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
        if (a >= 6'h32 && a <= 6'h37) model[6'h30][7] = 1'b0;
      end else begin
        d = wbuf[b];
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        if (!ro(a)) model[a] = d;
      end
      if (mb) a = a + 6'd1;
      if (b + 1 == mid_after) begin
        px = 16'($urandom); py = 16'($urandom); pz = 16'($urandom);
        pulse_sample(px, py, pz);
        if (rw) pend = 1'b1;
        else    model_sample(px, py, pz);
      end
    end
    if (abort_bits >= 0)
      for (int i = 0; i < abort_bits; i++) send_bit(1'($urandom_range(0, 1)));
    wait_h();
    cs_n = 1'b1;
    if (pend) model_sample(px, py, pz);
    wait_h(); wait_h();
    check("oe_idle", {15'h0, sdat_oe}, 16'h0);
    check("sdat_idle", {15'h0, sdat_o}, 16'h1);
    check("int_o", {15'h0, int_o}, {15'h0, exp_int()});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int op, n;
    model_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sdat_o", {15'h0, sdat_o}, 16'h1);
    check("rst_sdat_oe", {15'h0, sdat_oe}, 16'h0);
    check("rst_int_o", {15'h0, int_o}, 16'h0);

    // DEVID read
    spi_xfer(1'b1, 1'b0, 6'h00, 1, -1, 0);

    // sample then 6-byte multi-byte read, INT_SOURCE cleared afterwards
    sample_now(16'h0123, 16'hFF80, 16'h7FFF);
    spi_xfer(1'b1, 1'b1, 6'h32, 6, -1, 0);
    spi_xfer(1'b1, 1'b0, 6'h30, 1, -1, 0);

    // interrupt enable, rise within 2 clk, clear after reading a data byte
    wbuf[0] = 8'h80;
    spi_xfer(1'b0, 1'b0, 6'h2E, 1, -1, 0);
    pulse_sample(16'h1111, 16'h2222, 16'h3333);
    @(posedge clk); #1;
    check("int_rise", {15'h0, int_o}, 16'h1);
    model_sample(16'h1111, 16'h2222, 16'h3333);
    spi_xfer(1'b1, 1'b0, 6'h32, 1, -1, 0);

    // sample mid-burst stays coherent, new values visible afterwards
    sample_now(16'hA5A5, 16'h5A5A, 16'hC3C3);
    spi_xfer(1'b1, 1'b1, 6'h32, 6, -1, 2);
    spi_xfer(1'b1, 1'b1, 6'h32, 6, -1, 0);

    // read-only DEVID and address wrap on multi-byte write
    wbuf[0] = 8'h12;
    spi_xfer(1'b0, 1'b0, 6'h00, 1, -1, 0);
    spi_xfer(1'b1, 1'b0, 6'h00, 1, -1, 0);
    wbuf[0] = 8'h5A; wbuf[1] = 8'h77;
    spi_xfer(1'b0, 1'b1, 6'h3F, 2, -1, 0);
    spi_xfer(1'b1, 1'b1, 6'h3F, 2, -1, 0);

    // CS_N abort mid write byte leaves register untouched
    wbuf[0] = 8'hAA;
    spi_xfer(1'b0, 1'b0, 6'h10, 1, 5, 0);
    spi_xfer(1'b1, 1'b0, 6'h10, 1, -1, 0);

    // async reset mid read with a pending sample
    cs_n = 1'b0; wait_h();
    for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 6 || i == 5 || i == 4 || i == 1);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    pulse_sample(16'hDEAD, 16'hBEEF, 16'hCAFE);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("rst_mid_oe", {15'h0, sdat_oe}, 16'h0);
    check("rst_mid_sdat", {15'h0, sdat_o}, 16'h1);
    check("rst_mid_int", {15'h0, int_o}, 16'h0);
    model_reset();
    cs_n = 1'b1; sclk = 1'b1;
    wait_h();
    rst_n = 1'b1;
    wait_h();
    spi_xfer(1'b1, 1'b0, 6'h00, 1, -1, 0);
    spi_xfer(1'b1, 1'b1, 6'h2E, 10, -1, 0);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          n = $urandom_range(1, 3);
          for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
          spi_xfer(1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), n, -1,
                   $urandom_range(0, n));
        end
        1: begin
          n = $urandom_range(1, 4);
          spi_xfer(1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), n, -1,
                   $urandom_range(0, n));
        end
        2: begin
          sample_now(16'($urandom), 16'($urandom), 16'($urandom));
          repeat (3) @(negedge clk);
          check("int_after_sample", {15'h0, int_o}, {15'h0, exp_int()});
        end
        3: begin
          wbuf[0] = 8'($urandom);
          spi_xfer(1'b0, 1'b0, 6'h2E, 1, -1, 0);
        end
        default: begin
          spi_xfer(1'b1, 1'b1, 6'h32, 6, -1, $urandom_range(0, 6));
        end
      endcase
    end

    check("sb_drain", 16'(sb_q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
